// File: rtl/sr_flag_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter_pkg
//   Shared definitions for the SR flag arbiter slice: the operation encoding
//   carried on each requester's op line and the default bank dimensions.
// ---------------------------------------------------------------------------
package sr_flag_arbiter_pkg;

   // Operation requested on op[r]: set drives S, clear drives R.
   typedef enum logic {
      OP_CLR = 1'b0,
      OP_SET = 1'b1
   } op_e;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_NFLAG = 8;
   localparam int DEF_IDXW  = 3;

endpackage

// File: rtl/sr_flag_arbiter_cell.sv
// ---------------------------------------------------------------------------
// sr_cell
//   One SR flip-flop of the flag bank, synchronous active-high reset.
//   S=1 sets Q, R=1 clears Q, S=R=1 holds (the arbiter never produces it).
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous reset, active-high (Q=0, Qn=1)
//   S    in  set strobe
//   R    in  reset strobe
//   Q    out stored value (registered)
//   Qn   out complement of Q (registered alongside Q)
// ---------------------------------------------------------------------------
module sr_cell (
   input  logic clk,
   input  logic rst,
   input  logic S,
   input  logic R,
   output logic Q,
   output logic Qn
);

   logic q_r;
   logic qn_r;

   // SR storage with complementary output kept in its own register
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r  <= 1'b0;
         qn_r <= 1'b1;
      end else begin
         case ({S, R})
            2'b10: begin
               q_r  <= 1'b1;
               qn_r <= 1'b0;
            end
            2'b01: begin
               q_r  <= 1'b0;
               qn_r <= 1'b1;
            end
            default: begin
               q_r  <= q_r;
               qn_r <= qn_r;
            end
         endcase
      end
   end

   assign Q  = q_r;
   assign Qn = qn_r;

endmodule

// File: rtl/sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter
//   Round-robin arbiter sharing NFLAG SR flag cells between NREQ requesters.
//   One test-and-set / test-and-clear is executed per cycle; the grant, the
//   S/R strobe to the addressed cell, ack and ok all take effect at the same
//   edge, so the request-to-ack latency is one cycle.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous reset, active-high
//   req     in  [NREQ]       per-requester request, held until ack
//   op      in  [NREQ]       per-requester op, 1 = set, 0 = clear
//   idx     in  [NREQ*IDXW]  per-requester flag index, slice r*IDXW +: IDXW
//   ack     out [NREQ]       one-hot, one-cycle completion pulse
//   ok      out              old-value test result, 0 whenever ack = 0
//   flags   out [NFLAG]      Q of each cell
//   flags_n out [NFLAG]      Qn of each cell
// ---------------------------------------------------------------------------
module sr_flag_arbiter
   import sr_flag_arbiter_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int NFLAG = DEF_NFLAG,
   parameter int IDXW  = DEF_IDXW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      op,
   input  logic [NREQ*IDXW-1:0] idx,
   output logic [NREQ-1:0]      ack,
   output logic                 ok,
   output logic [NFLAG-1:0]     flags,
   output logic [NFLAG-1:0]     flags_n
);

   localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTRW-1:0]  ptr_r;
   logic [PTRW-1:0]  ptr_nxt_s;
   logic [NREQ-1:0]  ack_r;
   logic             ok_r;
   logic [NREQ-1:0]  elig_s;
   logic [NREQ-1:0]  gnt_s;
   logic             found_s;
   logic             win_op_s;
   logic [IDXW-1:0]  win_idx_s;
   logic             in_range_s;
   logic             old_s;
   logic             ok_nxt_s;
   logic [NFLAG-1:0] s_vec_s;
   logic [NFLAG-1:0] r_vec_s;
   logic [NFLAG-1:0] flags_s;
   logic [NFLAG-1:0] flags_n_s;

   // Rotating-priority winner: scan pointer..NREQ-1 first, then 0..pointer-1.
   // A requester acked last cycle is masked so its stale req cannot re-win.
   always_comb begin
      elig_s  = req & ~ack_r;
      gnt_s   = {NREQ{1'b0}};
      found_s = 1'b0;
      for (int r = 0; r < NREQ; r++) begin
         if (!found_s && elig_s[r] && (r >= int'(ptr_r))) begin
            gnt_s[r] = 1'b1;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
      for (int r = 0; r < NREQ; r++) begin
         if (!found_s && elig_s[r]) begin
            gnt_s[r] = 1'b1;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Pick the winner's operation and index, and advance the pointer past it
   always_comb begin
      win_op_s  = 1'b0;
      win_idx_s = {IDXW{1'b0}};
      ptr_nxt_s = ptr_r;
      for (int r = 0; r < NREQ; r++) begin
         if (gnt_s[r]) begin
            win_op_s  = op[r];
            win_idx_s = idx[r*IDXW +: IDXW];
            ptr_nxt_s = (r == NREQ - 1) ? {PTRW{1'b0}} : PTRW'(r + 1);
         end else begin
            win_op_s  = win_op_s;
         end
      end
      in_range_s = (int'(win_idx_s) < NFLAG);
   end

   // S/R decode: at most one cell strobed per cycle, never both lines on one
   // cell. Out-of-range indices touch nothing and report ok=0.
   always_comb begin
      s_vec_s = {NFLAG{1'b0}};
      r_vec_s = {NFLAG{1'b0}};
      old_s   = 1'b0;
      for (int f = 0; f < NFLAG; f++) begin
         if (found_s && in_range_s && (int'(win_idx_s) == f)) begin
            s_vec_s[f] = (win_op_s == OP_SET);
            r_vec_s[f] = (win_op_s == OP_CLR);
            old_s      = flags_s[f];
         end else begin
            old_s      = old_s;
         end
      end
      if (found_s && in_range_s) begin
         ok_nxt_s = (win_op_s == OP_SET) ? ~old_s : old_s;
      end else begin
         ok_nxt_s = 1'b0;
      end
   end

   // Pointer and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {PTRW{1'b0}};
         ack_r <= {NREQ{1'b0}};
         ok_r  <= 1'b0;
      end else begin
         if (found_s) begin
            ptr_r <= ptr_nxt_s;
         end else begin
            ptr_r <= ptr_r;
         end
         ack_r <= gnt_s;
         ok_r  <= ok_nxt_s;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NFLAG; g++) begin : g_cell
         sr_cell u_cell (
            .clk (clk),
            .rst (rst),
            .S   (s_vec_s[g]),
            .R   (r_vec_s[g]),
            .Q   (flags_s[g]),
            .Qn  (flags_n_s[g])
         );
      end
   endgenerate

   assign ack     = ack_r;
   assign ok      = ok_r;
   assign flags   = flags_s;
   assign flags_n = flags_n_s;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_arbiter
//   Directed scenarios followed by randomized requester traffic, every cycle
//   compared against a behavioural model of the flag bank and arbitration.
//   NFLAG=6 so that indices 6 and 7 are out of range.
// ---------------------------------------------------------------------------
module tb_sr_flag_arbiter;

   localparam int NREQ  = 4;
   localparam int NFLAG = 6;
   localparam int IDXW  = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      op;
   logic [NREQ*IDXW-1:0] idx;
   logic [NREQ-1:0]      ack;
   logic                 ok;
   logic [NFLAG-1:0]     flags;
   logic [NFLAG-1:0]     flags_n;

   always #5 clk = ~clk;

   sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .op      (op),
      .idx     (idx),
      .ack     (ack),
      .ok      (ok),
      .flags   (flags),
      .flags_n (flags_n)
   );

   int errors = 0;
   int checks = 0;

   // behavioural model state
   bit              m_flag [NFLAG];
   int              m_ptr;
   logic [NREQ-1:0] m_ack;
   logic            m_ok;
   logic [NREQ-1:0] prev_ack;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NFLAG-1:0] m_flags_vec();
      logic [NFLAG-1:0] v;
      for (int f = 0; f < NFLAG; f++) v[f] = m_flag[f];
      return v;
   endfunction

   // Apply the rules to the inputs present at the coming edge.
   task automatic model_edge();
      int w;
      int i;
      if (rst) begin
         for (int f = 0; f < NFLAG; f++) m_flag[f] = 1'b0;
         m_ptr = 0;
         m_ack = '0;
         m_ok  = 1'b0;
      end else begin
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            int r;
            r = (m_ptr + k) % NREQ;
            if (w < 0 && req[r] && !m_ack[r]) w = r;
         end
         if (w >= 0) begin
            i = int'(idx[w*IDXW +: IDXW]);
            m_ack    = '0;
            m_ack[w] = 1'b1;
            if (i < NFLAG) begin
               m_ok      = op[w] ? !m_flag[i] : m_flag[i];
               m_flag[i] = op[w];
            end else begin
               m_ok = 1'b0;
            end
            m_ptr = (w + 1) % NREQ;
         end else begin
            m_ack = '0;
            m_ok  = 1'b0;
         end
      end
   endtask

   task automatic tick();
      logic [NFLAG-1:0] ef;
      logic [NFLAG-1:0] efn;
      model_edge();
      @(posedge clk);
      #1;
      ef  = m_flags_vec();
      efn = ~ef;
      check_eq("ack", ack, m_ack);
      check_eq("ok", ok, m_ok);
      check_eq("flags", flags, ef);
      check_eq("flags_n", flags_n, efn);
      check_eq("ok_idle", (ack == '0) ? ok : 1'b0, 1'b0);
      check_eq("back_to_back", ack & prev_ack, '0);
      check_eq("s_r_excl", |(dut.s_vec_s & dut.r_vec_s), 1'b0);
      prev_ack = ack;
   endtask

   task automatic set_req(input int r, input bit o, input int i);
      op[r] = o;
      idx[r*IDXW +: IDXW] = i[IDXW-1:0];
   endtask

   initial begin
      rst = 1'b1;
      req = '1;
      op  = '1;
      idx = '0;
      prev_ack = '0;
      m_ack = '0;
      m_ok  = 1'b0;
      m_ptr = 0;
      for (int f = 0; f < NFLAG; f++) m_flag[f] = 1'b0;

      // 1. reset with every requester asserting
      for (int n = 0; n < 2; n++) begin
         tick();
         check_eq("rst_ack", ack, 4'b0000);
         check_eq("rst_flags", flags, 6'h00);
         check_eq("rst_flags_n", flags_n, 6'h3F);
      end
      rst = 1'b0;
      req = '0;
      tick();

      // 2. set idx3 twice from requester 0
      req = 4'b0001;
      set_req(0, 1'b1, 3);
      tick();
      check_eq("t2_ack", ack, 4'b0001);
      check_eq("t2_ok", ok, 1'b1);
      check_eq("t2_flags", flags, 6'h08);
      tick();
      check_eq("t2_mask", ack, 4'b0000);
      tick();
      check_eq("t2_re_ack", ack, 4'b0001);
      check_eq("t2_re_ok", ok, 1'b0);
      check_eq("t2_re_flags", flags, 6'h08);
      req = '0;
      tick();

      // 3. same-flag conflict with pointer at 1
      req = 4'b0110;
      set_req(1, 1'b1, 5);
      set_req(2, 1'b0, 5);
      tick();
      check_eq("t3_ack1", ack, 4'b0010);
      check_eq("t3_ok1", ok, 1'b1);
      check_eq("t3_flags1", flags, 6'h28);
      req = 4'b0100;
      tick();
      check_eq("t3_ack2", ack, 4'b0100);
      check_eq("t3_ok2", ok, 1'b1);
      check_eq("t3_flags2", flags, 6'h08);
      req = '0;
      tick();

      // 4. fairness between requesters 0 and 3 (pointer is at 3)
      req = 4'b1001;
      set_req(0, 1'b1, 0);
      set_req(3, 1'b1, 1);
      for (int n = 0; n < 8; n++) begin
         tick();
         check_eq("t4_alt", ack, (n % 2 == 0) ? 4'b1000 : 4'b0001);
      end
      req = '0;
      tick();

      // 5. out-of-range index
      req = 4'b0100;
      set_req(2, 1'b1, 7);
      tick();
      check_eq("t5_ack", ack, 4'b0100);
      check_eq("t5_ok", ok, 1'b0);
      check_eq("t5_flags", flags, 6'h0B);
      req = '0;
      tick();

      // 6. reset with three pending requests
      req = 4'b0111;
      set_req(0, 1'b1, 2);
      set_req(1, 1'b1, 3);
      set_req(2, 1'b0, 4);
      rst = 1'b1;
      tick();
      check_eq("t6_rst_ack", ack, 4'b0000);
      check_eq("t6_rst_flags", flags, 6'h00);
      rst = 1'b0;
      tick();
      check_eq("t6_first", ack, 4'b0001);
      req = '0;
      tick();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (ack[r]) begin
               if ($urandom_range(1, 0) == 0) begin
                  req[r] = 1'b0;
               end else begin
                  set_req(r, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
               end
            end else if (!req[r] && $urandom_range(2, 0) == 0) begin
               req[r] = 1'b1;
               set_req(r, 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
            end
         end
         rst = ($urandom_range(99, 0) == 0);
         tick();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
